// File: rtl/rx_cmd_decoder.sv
// rtl/rx_cmd_decoder.sv - UART RX command-frame parser driving register file and ALU requests
module rx_cmd_decoder #(
  parameter int DW          = 8,
  parameter int AW          = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [DW-1:0] RX_P_DATA,
  input  logic          RX_D_VLD,
  input  logic          RX_PAR_ERR,
  input  logic          RX_STP_ERR,
  input  logic          RESP_BUSY,
  output logic          RF_WrEn,
  output logic          RF_RdEn,
  output logic [AW-1:0] RF_Address,
  output logic [DW-1:0] RF_WrData,
  output logic          ALU_EN,
  output logic [3:0]    ALU_FUN,
  output logic          CLK_GATE_EN,
  output logic          FRAME_ERR,
  output logic          CMD_BUSY
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_RD_ISSUE,
    S_OPA, S_OPB, S_FUN, S_ALU_GATE, S_ALU_ISSUE
  } state_t;

  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYC - 1);

  localparam logic [DW-1:0] CMD_WR  = DW'(8'hAA);
  localparam logic [DW-1:0] CMD_RD  = DW'(8'hBB);
  localparam logic [DW-1:0] CMD_ALU = DW'(8'hCC);
  localparam logic [DW-1:0] CMD_FUN = DW'(8'hDD);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [AW-1:0] addr_q, addr_n;
  logic [AW-1:0] rf_addr_n;
  logic [DW-1:0] wdata_n;
  logic [3:0]    fun_n;
  logic          wr_en_n, rd_en_n, ferr_n;
  logic          byte_ok, byte_bad;

  assign byte_ok  = RX_D_VLD & ~RX_PAR_ERR & ~RX_STP_ERR;
  assign byte_bad = RX_D_VLD & (RX_PAR_ERR | RX_STP_ERR);

  // State, timeout counter, latched address and every output are registered here
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= S_IDLE;
      cnt         <= '0;
      addr_q      <= '0;
      RF_WrEn     <= 1'b0;
      RF_RdEn     <= 1'b0;
      RF_Address  <= '0;
      RF_WrData   <= '0;
      ALU_EN      <= 1'b0;
      ALU_FUN     <= '0;
      CLK_GATE_EN <= 1'b0;
      FRAME_ERR   <= 1'b0;
      CMD_BUSY    <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      addr_q      <= addr_n;
      RF_WrEn     <= wr_en_n;
      RF_RdEn     <= rd_en_n;
      RF_Address  <= rf_addr_n;
      RF_WrData   <= wdata_n;
      ALU_FUN     <= fun_n;
      FRAME_ERR   <= ferr_n;
      ALU_EN      <= (state_n == S_ALU_ISSUE);
      CLK_GATE_EN <= (state_n == S_ALU_GATE) || (state_n == S_ALU_ISSUE);
      CMD_BUSY    <= (state_n != S_IDLE);
    end
  end

  // Next-state and next-output decode; data outputs hold unless a strobe is issued
  always_comb begin
    state_n   = state;
    cnt_n     = '0;
    addr_n    = addr_q;
    rf_addr_n = RF_Address;
    wdata_n   = RF_WrData;
    fun_n     = ALU_FUN;
    wr_en_n   = 1'b0;
    rd_en_n   = 1'b0;
    ferr_n    = 1'b0;
    case (state)
      S_IDLE: begin
        if (byte_ok) begin
          case (RX_P_DATA)
            CMD_WR:  state_n = S_WR_ADDR;
            CMD_RD:  state_n = S_RD_ADDR;
            CMD_ALU: state_n = S_OPA;
            CMD_FUN: state_n = S_FUN;
            default: ferr_n = 1'b1;
          endcase
        end else if (byte_bad) begin
          ferr_n = 1'b1;
        end
      end
      S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_OPA, S_OPB, S_FUN: begin
        if (byte_bad) begin
          state_n = S_IDLE;
          ferr_n  = 1'b1;
        end else if (byte_ok) begin
          case (state)
            S_WR_ADDR: begin
              addr_n  = RX_P_DATA[AW-1:0];
              state_n = S_WR_DATA;
            end
            S_WR_DATA: begin
              wr_en_n   = 1'b1;
              rf_addr_n = addr_q;
              wdata_n   = RX_P_DATA;
              state_n   = S_IDLE;
            end
            S_RD_ADDR: begin
              addr_n = RX_P_DATA[AW-1:0];
              // Issue straight away when the response path is free so the
              // read strobe lands one cycle after the address byte
              if (!RESP_BUSY) begin
                rd_en_n   = 1'b1;
                rf_addr_n = RX_P_DATA[AW-1:0];
                state_n   = S_IDLE;
              end else begin
                state_n = S_RD_ISSUE;
              end
            end
            S_OPA: begin
              wr_en_n   = 1'b1;
              rf_addr_n = '0;
              wdata_n   = RX_P_DATA;
              state_n   = S_OPB;
            end
            S_OPB: begin
              wr_en_n   = 1'b1;
              rf_addr_n = AW'(1);
              wdata_n   = RX_P_DATA;
              state_n   = S_FUN;
            end
            S_FUN: begin
              fun_n   = RX_P_DATA[3:0];
              state_n = S_ALU_GATE;
            end
            default: state_n = S_IDLE;
          endcase
        end else if (cnt == CNT_MAX) begin
          state_n = S_IDLE;
          ferr_n  = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_RD_ISSUE: begin
        ferr_n = RX_D_VLD;
        if (!RESP_BUSY) begin
          rd_en_n   = 1'b1;
          rf_addr_n = addr_q;
          state_n   = S_IDLE;
        end
      end
      S_ALU_GATE: begin
        ferr_n = RX_D_VLD;
        if (!RESP_BUSY) state_n = S_ALU_ISSUE;
      end
      S_ALU_ISSUE: begin
        ferr_n  = RX_D_VLD;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_rx_cmd_decoder.sv
// tb/tb_rx_cmd_decoder.sv - scoreboard bench for rx_cmd_decoder
module tb_rx_cmd_decoder;
  localparam int TO = 1024;
  localparam int K_WR = 0, K_RD = 1, K_ALU = 2, K_FE = 3;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] RX_P_DATA = 8'h00;
  logic       RX_D_VLD = 1'b0, RX_PAR_ERR = 1'b0, RX_STP_ERR = 1'b0, RESP_BUSY = 1'b0;
  logic       RF_WrEn, RF_RdEn, ALU_EN, CLK_GATE_EN, FRAME_ERR, CMD_BUSY;
  logic [3:0] RF_Address, ALU_FUN;
  logic [7:0] RF_WrData;

  typedef struct {int kind; int a; int d; int c;} ev_t;
  ev_t sb[$];
  int  checks = 0, errors = 0, cyc = 0;
  logic prev_gate = 1'b0, prev_alu = 1'b0;

  rx_cmd_decoder #(.DW(8), .AW(4), .TIMEOUT_CYC(TO)) dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RX_PAR_ERR(RX_PAR_ERR), .RX_STP_ERR(RX_STP_ERR), .RESP_BUSY(RESP_BUSY),
    .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn), .RF_Address(RF_Address), .RF_WrData(RF_WrData),
    .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .CLK_GATE_EN(CLK_GATE_EN),
    .FRAME_ERR(FRAME_ERR), .CMD_BUSY(CMD_BUSY)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void push(input int k, input int a, input int d, input int c);
    ev_t e;
    e.kind = k; e.a = a; e.d = d; e.c = c;
    sb.push_back(e);
  endfunction

  task automatic take(input int kind, input int a, input int d);
    ev_t e;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL unexpected_event kind %0d observed at cyc %0d expected none", kind, cyc);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("ev_kind", kind, e.kind);
      chk("ev_cyc", cyc, e.c);
      if (e.kind == K_WR || e.kind == K_RD) chk("ev_addr", a, e.a);
      if (e.kind == K_WR || e.kind == K_ALU) chk("ev_data", d, e.d);
    end
  endtask

  // Output monitor: every strobe must match the head of the scoreboard
  always @(negedge CLK) begin
    if (RST) begin
      if (RF_WrEn) take(K_WR, RF_Address, RF_WrData);
      if (RF_RdEn) take(K_RD, RF_Address, 0);
      if (ALU_EN) begin
        take(K_ALU, 0, ALU_FUN);
        chk("gate_lead", prev_gate, 1);
        chk("gate_with_en", CLK_GATE_EN, 1);
      end
      if (prev_alu) chk("gate_drop", CLK_GATE_EN, 0);
      if (FRAME_ERR) take(K_FE, 0, 0);
    end
    prev_gate = CLK_GATE_EN;
    prev_alu  = ALU_EN;
  end

  task automatic send(input logic [7:0] b, input logic pe, input logic se);
    RX_P_DATA = b; RX_PAR_ERR = pe; RX_STP_ERR = se; RX_D_VLD = 1'b1;
    @(negedge CLK);
    RX_D_VLD = 1'b0; RX_PAR_ERR = 1'b0; RX_STP_ERR = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge CLK);
    chk(tag, sb.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired observed running expected finished");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge CLK);
    chk("rst_wren", RF_WrEn, 0);
    chk("rst_rden", RF_RdEn, 0);
    chk("rst_addr", RF_Address, 0);
    chk("rst_busy", CMD_BUSY, 0);
    chk("rst_gate", CLK_GATE_EN, 0);
    RST = 1'b1;
    @(negedge CLK);

    // write frame
    send(8'hAA, 0, 0);
    send(8'h05, 0, 0);
    chk("wr_busy_mid", CMD_BUSY, 1);
    push(K_WR, 5, 8'h3C, cyc + 1);
    send(8'h3C, 0, 0);
    chk("wr_busy_after", CMD_BUSY, 0);
    chk("hold_addr", RF_Address, 5);
    chk("hold_data", RF_WrData, 8'h3C);
    drain("drain_wr");

    // read frame stalled by RESP_BUSY, with a dropped byte during the stall
    RESP_BUSY = 1'b1;
    send(8'hBB, 0, 0);
    send(8'h07, 0, 0);
    push(K_FE, 0, 0, cyc + 1);
    send(8'h99, 0, 0);
    repeat (14) @(negedge CLK);
    chk("rd_stall_busy", CMD_BUSY, 1);
    push(K_RD, 7, 0, cyc + 1);
    RESP_BUSY = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rd_busy_after", CMD_BUSY, 0);
    drain("drain_rd");

    // ALU frame with operands
    send(8'hCC, 0, 0);
    push(K_WR, 0, 8'h12, cyc + 1);
    send(8'h12, 0, 0);
    push(K_WR, 1, 8'h34, cyc + 1);
    send(8'h34, 0, 0);
    push(K_ALU, 0, 1, cyc + 2);
    send(8'h01, 0, 0);
    drain("drain_alu");
    chk("alu_gate_off", CLK_GATE_EN, 0);

    // parity error mid-frame aborts, then a function-only frame
    send(8'hAA, 0, 0);
    send(8'h05, 0, 0);
    push(K_FE, 0, 0, cyc + 1);
    send(8'h3C, 1, 0);
    chk("abort_idle", CMD_BUSY, 0);
    send(8'hDD, 0, 0);
    push(K_ALU, 0, 2, cyc + 2);
    send(8'h02, 0, 0);
    drain("drain_fun");

    // stop error on a byte while idle
    push(K_FE, 0, 0, cyc + 1);
    send(8'hAA, 0, 1);
    chk("stp_idle", CMD_BUSY, 0);

    // timeout on an unfinished read
    push(K_FE, 0, 0, cyc + 1 + TO);
    send(8'hBB, 0, 0);
    repeat (TO + 2) @(negedge CLK);
    chk("to_idle", CMD_BUSY, 0);
    drain("drain_to");

    // unknown command byte
    push(K_FE, 0, 0, cyc + 1);
    send(8'h55, 0, 0);
    drain("drain_unk");

    // reset mid-frame
    send(8'hCC, 0, 0);
    push(K_WR, 0, 8'h12, cyc + 1);
    send(8'h12, 0, 0);
    RST = 1'b0;
    #1;
    chk("mid_rst_busy", CMD_BUSY, 0);
    chk("mid_rst_addr", RF_Address, 0);
    chk("mid_rst_data", RF_WrData, 0);
    chk("mid_rst_wren", RF_WrEn, 0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    send(8'hAA, 0, 0);
    send(8'h01, 0, 0);
    push(K_WR, 1, 8'hFF, cyc + 1);
    send(8'hFF, 0, 0);
    drain("drain_post_rst");

    repeat (5) @(negedge CLK);
    chk("sb_empty_end", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
